// File: rtl/draw_scheduler.sv
// Frame sequencer sharing one VGA plot port: erase, update, capture, redraw of NUM_OBJ box sprites.
// Latency: x/y/colour/plot registered, one cycle after the walk counters; frame = 2*NUM_OBJ*SIZE^2+3 cycles max.
// No backpressure: the adapter accepts a pixel every cycle; a tick during a busy frame queues one-deep, then overruns.
// Optional feature: define DRAW_SCHED_CLIP_EN to suppress plots whose x>159 or y>119 before the wrap.
module draw_scheduler #(
    parameter int NUM_OBJ   = 4,
    parameter int SIZE      = 4,
    parameter int FRAME_DIV = 833333
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*NUM_OBJ-1:0] obj_x,
    input  logic [7*NUM_OBJ-1:0] obj_y,
    input  logic [3*NUM_OBJ-1:0] obj_colour,
    input  logic [NUM_OBJ-1:0]   obj_en,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 update,
    output logic                 busy,
    output logic                 frame_overrun
);
    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW = $clog2(FRAME_DIV + 1);
    localparam logic [IW-1:0] LAST_OBJ = IW'(NUM_OBJ - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(SIZE - 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(FRAME_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_UPDATE, S_CAPTURE, S_DRAW} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] div_cnt;
    logic          tick, pending, leave_idle;
    logic [IW-1:0] idx;
    logic [PW-1:0] col, row;

    // Positions last drawn (erase source) and the per-frame snapshot (draw source)
    logic [7:0]         prev_x   [NUM_OBJ];
    logic [6:0]         prev_y   [NUM_OBJ];
    logic [NUM_OBJ-1:0] prev_valid;
    logic [7:0]         snap_x   [NUM_OBJ];
    logic [6:0]         snap_y   [NUM_OBJ];
    logic [2:0]         snap_col [NUM_OBJ];
    logic [NUM_OBJ-1:0] snap_en;

    logic       erasing, walking, cur_valid, last_pix, step_obj, clip;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    assign tick       = (div_cnt == LAST_DIV);
    assign leave_idle = (state == S_IDLE) && pending;

    // Free-running frame divider, wraps on terminal count
    always_ff @(posedge clk) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // One-deep tick queue; a new tick wins over the clear when leaving IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= tick && pending && !leave_idle;
            if (tick)            pending <= 1'b1;
            else if (leave_idle) pending <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Current walk pixel: source selection, address arithmetic, per-object step
    always_comb begin
        erasing   = (state == S_ERASE);
        walking   = erasing || (state == S_DRAW);
        cur_valid = erasing ? prev_valid[idx] : snap_en[idx];
        base_x    = erasing ? prev_x[idx] : snap_x[idx];
        base_y    = erasing ? prev_y[idx] : snap_y[idx];
        last_pix  = (col == LAST_PIX) && (row == LAST_PIX);
        step_obj  = !cur_valid || last_pix;
        sum_x     = {1'b0, base_x} + 9'(col);
        sum_y     = {1'b0, base_y} + 8'(row);
    end

`ifdef DRAW_SCHED_CLIP_EN
    assign clip = (sum_x > 9'd159) || (sum_y > 8'd119);
`else
    // Wrapping mode: carry-out bits are dropped, the adapter discards off-screen pixels
    assign clip = 1'b0 & sum_x[8] & sum_y[7];
`endif

    // Next-state: walk ERASE then DRAW across all objects, single-cycle UPDATE/CAPTURE between
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pending) state_nxt = S_ERASE;
            S_ERASE:   if (step_obj && idx == LAST_OBJ) state_nxt = S_UPDATE;
            S_UPDATE:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DRAW;
            S_DRAW:    if (step_obj && idx == LAST_OBJ) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Registered pixel outputs, strobes and walk counters (object, column, row)
    always_ff @(posedge clk) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            update <= 1'b0;
            busy   <= 1'b0;
            idx    <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            x      <= sum_x[7:0];
            y      <= sum_y[6:0];
            colour <= erasing ? 3'b000 : snap_col[idx];
            plot   <= walking && cur_valid && !clip;
            update <= (state_nxt == S_UPDATE);
            busy   <= (state_nxt != S_IDLE);
            if (walking) begin
                if (step_obj) begin
                    col <= '0;
                    row <= '0;
                    idx <= (idx == LAST_OBJ) ? '0 : idx + 1'b1;
                end else if (col == LAST_PIX) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Validity flags: snapshot enable at capture, remembered as drawn-state during DRAW
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid <= '0;
            snap_en    <= '0;
        end else begin
            if (state == S_CAPTURE) snap_en <= obj_en;
            if (state == S_DRAW)    prev_valid[idx] <= snap_en[idx];
        end
    end

    // Coordinate snapshot and last-drawn position storage
    always_ff @(posedge clk) begin
        if (state == S_CAPTURE) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                snap_x[i]   <= obj_x[8*i +: 8];
                snap_y[i]   <= obj_y[7*i +: 7];
                snap_col[i] <= obj_colour[3*i +: 3];
            end
        end
        if (state == S_DRAW) begin
            prev_x[idx] <= snap_x[idx];
            prev_y[idx] <= snap_y[idx];
        end
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: two 4x4 objects, frame tick every 200 cycles, plus a fast-tick instance.
// Pixel stream captured on the falling edge and compared to hand-computed coordinates per frame.
// Expectations for off-screen pixels follow DRAW_SCHED_CLIP_EN when it is defined for the build.
module tb_draw_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] obj_x;
    logic [13:0] obj_y;
    logic [5:0]  obj_colour;
    logic [1:0]  obj_en;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, update, busy, frame_overrun;
    logic [7:0]  f_x;
    logic [6:0]  f_y;
    logic [2:0]  f_colour;
    logic        f_plot, f_update, f_busy, f_overrun;

    int tests_run = 0;
    int tests_failed = 0;
    logic [17:0] plots[$];
    int busy_cycles = 0;
    int upd_cnt = 0;
    int ovr_main = 0;
    int ovr_fast = 0;

    always #5 clk = ~clk;

    draw_scheduler #(.NUM_OBJ(2), .SIZE(4), .FRAME_DIV(200)) dut (
        .clk(clk), .reset(reset), .obj_x(obj_x), .obj_y(obj_y),
        .obj_colour(obj_colour), .obj_en(obj_en), .x(x), .y(y),
        .colour(colour), .plot(plot), .update(update), .busy(busy),
        .frame_overrun(frame_overrun)
    );

    draw_scheduler #(.NUM_OBJ(2), .SIZE(4), .FRAME_DIV(20)) u_fast (
        .clk(clk), .reset(reset), .obj_x(obj_x), .obj_y(obj_y),
        .obj_colour(obj_colour), .obj_en(obj_en), .x(f_x), .y(f_y),
        .colour(f_colour), .plot(f_plot), .update(f_update), .busy(f_busy),
        .frame_overrun(f_overrun)
    );

    // Pixel and strobe monitor
    always @(negedge clk) begin
        if (plot) plots.push_back({x, y, colour});
        if (busy) busy_cycles++;
        if (update) upd_cnt++;
        if (frame_overrun) ovr_main++;
        if (f_overrun) ovr_fast++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int px, input int py, input int pc);
        return {14'd0, 8'(px), 7'(py), 3'(pc)};
    endfunction

    function automatic logic [31:0] at(input int i);
        if (i < plots.size()) return {14'd0, plots[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int cnt_black();
        int n = 0;
        foreach (plots[i]) if (plots[i][2:0] == 3'd0) n++;
        return n;
    endfunction

    function automatic int cnt_xge(input int v);
        int n = 0;
        foreach (plots[i]) if (int'(plots[i][17:10]) >= v) n++;
        return n;
    endfunction

    task automatic set_obj(input int i, input int px, input int py, input int pc);
        obj_x[8*i +: 8]      = 8'(px);
        obj_y[7*i +: 7]      = 7'(py);
        obj_colour[3*i +: 3] = 3'(pc);
    endtask

    // Wait for one whole frame (busy rise then fall), bounded
    task automatic run_frame(input string tag);
        int n;
        plots.delete();
        busy_cycles = 0;
        upd_cnt = 0;
        n = 0;
        while (!busy && n < 400) begin @(negedge clk); n++; end
        chk({tag, " start"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk({tag, " end"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        obj_en = 2'b11;
        obj_x = '0; obj_y = '0; obj_colour = '0;
        set_obj(0, 10, 20, 1);
        set_obj(1, 50, 60, 2);
        repeat (3) @(negedge clk);
        chk("rst x", 32'(x), 0);
        chk("rst y", 32'(y), 0);
        chk("rst colour", 32'(colour), 0);
        chk("rst plot", 32'(plot), 0);
        chk("rst update", 32'(update), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst overrun", 32'(frame_overrun), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Frame 1: nothing drawn yet, two idle erase cycles then 32 draw pixels
        run_frame("f1");
        chk("f1 plots", 32'(plots.size()), 32);
        chk("f1 black", 32'(cnt_black()), 0);
        chk("f1 update", 32'(upd_cnt), 1);
        chk("f1 busy", 32'(busy_cycles), 36);
        chk("f1 p0", at(0), pk(10, 20, 1));
        chk("f1 p5", at(5), pk(11, 21, 1));
        chk("f1 p16", at(16), pk(50, 60, 2));
        chk("f1 p31", at(31), pk(53, 63, 2));

        // Frame 2: movers shifted x by +2
        set_obj(0, 12, 20, 1);
        set_obj(1, 52, 60, 2);
        run_frame("f2");
        chk("f2 plots", 32'(plots.size()), 64);
        chk("f2 black", 32'(cnt_black()), 32);
        chk("f2 busy", 32'(busy_cycles), 66);
        chk("f2 p0", at(0), pk(10, 20, 0));
        chk("f2 p15", at(15), pk(13, 23, 0));
        chk("f2 p16", at(16), pk(50, 60, 0));
        chk("f2 p31", at(31), pk(53, 63, 0));
        chk("f2 p32", at(32), pk(12, 20, 1));
        chk("f2 p63", at(63), pk(55, 63, 2));

        // Frame 3: object 1 disabled, erased once
        obj_en = 2'b01;
        run_frame("f3");
        chk("f3 plots", 32'(plots.size()), 48);
        chk("f3 obj1 px", 32'(cnt_xge(50)), 16);
        chk("f3 busy", 32'(busy_cycles), 51);
        chk("f3 p47", at(47), pk(15, 23, 1));

        // Frame 4: object 1 gone entirely
        run_frame("f4");
        chk("f4 plots", 32'(plots.size()), 32);
        chk("f4 obj1 px", 32'(cnt_xge(50)), 0);
        chk("f4 busy", 32'(busy_cycles), 36);

        // Frame 5: object at the bottom-right screen corner
        set_obj(0, 158, 118, 1);
        run_frame("f5");
        chk("f5 p16", at(16), pk(158, 118, 1));
        chk("f5 p17", at(17), pk(159, 118, 1));
`ifdef DRAW_SCHED_CLIP_EN
        chk("f5 plots", 32'(plots.size()), 20);
        chk("f5 p19", at(19), pk(159, 119, 1));
`else
        chk("f5 plots", 32'(plots.size()), 32);
        chk("f5 p19", at(19), pk(161, 118, 1));
        chk("f5 p31", at(31), pk(161, 121, 1));
`endif

        // Frame 6: coordinates crossing the 8-bit / 7-bit wrap
        set_obj(0, 254, 126, 1);
        run_frame("f6");
`ifdef DRAW_SCHED_CLIP_EN
        chk("f6 plots", 32'(plots.size()), 4);
        chk("f6 p3", at(3), pk(159, 119, 0));
`else
        chk("f6 plots", 32'(plots.size()), 32);
        chk("f6 p16", at(16), pk(254, 126, 1));
        chk("f6 p18", at(18), pk(0, 126, 1));
        chk("f6 p31", at(31), pk(1, 1, 1));
`endif

        // Frame 7: reset while drawing
        set_obj(0, 30, 40, 1);
        set_obj(1, 52, 60, 2);
        obj_en = 2'b11;
        n = 0;
        while (!(plot && colour != 3'd0) && n < 800) begin @(negedge clk); n++; end
        chk("f7 in draw", 32'(plot && colour != 3'd0), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("f7 rst plot", 32'(plot), 0);
        chk("f7 rst busy", 32'(busy), 0);
        reset = 1'b0;

        // Frame 8: nothing remembered, so no erase pixels
        run_frame("f8");
        chk("f8 plots", 32'(plots.size()), 32);
        chk("f8 black", 32'(cnt_black()), 0);
        chk("f8 busy", 32'(busy_cycles), 36);
        chk("f8 p0", at(0), pk(30, 40, 1));
        chk("f8 p31", at(31), pk(55, 63, 2));

        // Overrun behaviour across the whole run
        chk("overrun main", 32'(ovr_main), 0);
        chk("overrun fast seen", 32'(ovr_fast > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
